// File: rtl/turn_signal_conditioner.sv
// ---------------------------------------------------------------------------
// turn_signal_conditioner
//
// Front-end conditioner for the turn-signal sequencer. It takes the raw,
// asynchronous, bouncing left/right switches, synchronises and debounces each
// one, and decodes the pair through a break-before-make mode FSM. The outputs
// are clean request levels for the light sequencer plus one-cycle rise pulses.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive clk cycles a synced input must disagree with
//                     its stable value before the stable value flips (>= 2)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset (0 = reset)
//   left       in   raw left switch (asynchronous, may bounce)
//   right      in   raw right switch (asynchronous, may bounce)
//   left_req   out  registered left request to the sequencer
//   right_req  out  registered right request to the sequencer
//   hazard     out  registered, high while the mode FSM is in HAZARD
//   left_rise  out  one-cycle pulse when debounced left goes 0->1
//   right_rise out  one-cycle pulse when debounced right goes 0->1
// ---------------------------------------------------------------------------
module turn_signal_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  output logic left_req,
  output logic right_req,
  output logic hazard,
  output logic left_rise,
  output logic right_rise
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEFT   = 2'd1,
    ST_RIGHT  = 2'd2,
    ST_HAZARD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel index 1 is left, index 0 is right throughout.
  logic [1:0]       w_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_stable;
  logic [1:0]       r_rise;
  logic [CNT_W-1:0] r_cnt [2];

  state_t r_state;
  state_t w_target;
  logic   r_leftReq;
  logic   r_rightReq;
  logic   r_hazard;

  assign w_raw = {left, right};

  // Two-flop synchroniser followed by a run-length debouncer per channel.
  // The counter measures how many consecutive cycles the synced value has
  // disagreed with the stable value; any agreement restarts it. The rise pulse
  // is registered on the same edge that the stable value flips to 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_stable <= '0;
      r_rise   <= '0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        r_rise[i] <= 1'b0;
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_CNT_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
          r_rise[i]   <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Desired mode from the debounced pair; a simultaneous flip of both
  // channels naturally lands as one target change.
  always_comb begin
    w_target = ST_IDLE;
    case (r_stable)
      2'b10:   w_target = ST_LEFT;
      2'b01:   w_target = ST_RIGHT;
      2'b11:   w_target = ST_HAZARD;
      default: w_target = ST_IDLE;
    endcase
  end

  // Break-before-make mode FSM. From IDLE jump straight to the target; from
  // any active mode, a changed target always passes through IDLE for one
  // cycle so the sequencer never sees two requests overlap mid-change.
  // Outputs are decoded from the current state and registered, so they lag
  // the state by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_leftReq  <= 1'b0;
      r_rightReq <= 1'b0;
      r_hazard   <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_state <= w_target;
      end else if (w_target != r_state) begin
        r_state <= ST_IDLE;
      end

      r_leftReq  <= (r_state == ST_LEFT)  || (r_state == ST_HAZARD);
      r_rightReq <= (r_state == ST_RIGHT) || (r_state == ST_HAZARD);
      r_hazard   <= (r_state == ST_HAZARD);
    end
  end

  assign left_req   = r_leftReq;
  assign right_req  = r_rightReq;
  assign hazard     = r_hazard;
  assign left_rise  = r_rise[1];
  assign right_rise = r_rise[0];

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// ---------------------------------------------------------------------------
// tb_turn_signal_conditioner
//
// Self-checking bench for turn_signal_conditioner with a short debounce.
// A reference model tracks the raw input history and derives the debounced
// levels from a sliding window, then applies the mode rules, and every
// cycle the DUT outputs are compared against it. Directed sequences and a
// table of steady-state vectors check the exact latencies and mode paths.
// ---------------------------------------------------------------------------
module tb_turn_signal_conditioner;

  localparam int D = 4;

  logic clk;
  logic reset;
  logic left;
  logic right;
  logic left_req;
  logic right_req;
  logic hazard;
  logic left_rise;
  logic right_rise;

  int checks;
  int errors;
  int riseCountL;

  // Reference model state: raw history (newest first), debounced levels,
  // mode as {L,R} code, and the expected registered outputs.
  bit histL[$];
  bit histR[$];
  bit mStableL, mStableR;
  int mMode;
  bit mLReq, mRReq, mHaz, mLRise, mRRise;

  typedef struct {
    bit       l;
    bit       r;
    int       hold;
    bit [2:0] expReq;
  } vec_t;

  vec_t vecs[8];

  turn_signal_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .left(left),
    .right(right),
    .left_req(left_req),
    .right_req(right_req),
    .hazard(hazard),
    .left_rise(left_rise),
    .right_rise(right_rise)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reports one comparison.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelClear();
    histL.delete();
    histR.delete();
    mStableL = 0; mStableR = 0;
    mMode = 0;
    mLReq = 0; mRReq = 0; mHaz = 0; mLRise = 0; mRRise = 0;
  endtask

  // The debouncer at an edge sees the raw value sampled two edges earlier;
  // it flips once the last D such values all disagree with the stable level.
  function automatic bit windowFlip(input bit hist[$], input bit stable);
    bit v;
    for (int j = 2; j <= D + 1; j++) begin
      v = (hist.size() > j) ? hist[j] : 1'b0;
      if (v == stable) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelStep(input bit rawL, input bit rawR);
    int target;
    bit flipL, flipR;
    target = (mStableL ? 2 : 0) + (mStableR ? 1 : 0);
    mLReq = (mMode == 2) || (mMode == 3);
    mRReq = (mMode == 1) || (mMode == 3);
    mHaz  = (mMode == 3);
    if (mMode == 0) mMode = target;
    else if (target != mMode) mMode = 0;
    histL.push_front(rawL);
    histR.push_front(rawR);
    while (histL.size() > D + 2) void'(histL.pop_back());
    while (histR.size() > D + 2) void'(histR.pop_back());
    flipL = windowFlip(histL, mStableL);
    flipR = windowFlip(histR, mStableR);
    mLRise = flipL && !mStableL;
    mRRise = flipR && !mStableR;
    mStableL = mStableL ^ flipL;
    mStableR = mStableR ^ flipR;
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare all outputs shortly after.
  task automatic tick();
    @(posedge clk);
    if (!reset) modelClear();
    else modelStep(left, right);
    #1;
    checkOutput("cycle outputs",
                {3'b0, left_req, right_req, hazard, left_rise, right_rise},
                {3'b0, mLReq, mRReq, mHaz, mLRise, mRRise});
    if (left_rise === 1'b1) riseCountL++;
  endtask

  task automatic applyStimulus(input bit l, input bit r, input int n);
    left  = l;
    right = r;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asserts reset between edges and confirms outputs clear without a clock.
  task automatic asyncReset(input int lowEdges);
    #2;
    reset = 1'b0;
    modelClear();
    #1;
    checkOutput("async reset clears outputs",
                {3'b0, left_req, right_req, hazard, left_rise, right_rise}, 8'd0);
    for (int i = 0; i < lowEdges; i++) tick();
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    riseCountL = 0;
    modelClear();

    vecs[0] = '{l: 1, r: 0, hold: 10, expReq: 3'b100};
    vecs[1] = '{l: 0, r: 1, hold: 10, expReq: 3'b010};
    vecs[2] = '{l: 1, r: 1, hold: 10, expReq: 3'b111};
    vecs[3] = '{l: 0, r: 0, hold: 10, expReq: 3'b000};
    vecs[4] = '{l: 1, r: 1, hold: 10, expReq: 3'b111};
    vecs[5] = '{l: 0, r: 1, hold: 10, expReq: 3'b010};
    vecs[6] = '{l: 1, r: 0, hold: 10, expReq: 3'b100};
    vecs[7] = '{l: 0, r: 0, hold: 10, expReq: 3'b000};

    // Reset held with both switches on: outputs stay clear.
    reset = 1'b0;
    left  = 1'b1;
    right = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("reset state", {3'b0, left_req, right_req, hazard, left_rise, right_rise}, 8'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 5) checkOutput("release rises", {6'b0, left_rise, right_rise}, 8'b11);
      if (i == 6) checkOutput("release reqs early", {5'b0, left_req, right_req, hazard}, 8'b000);
      if (i == 7) checkOutput("release hazard", {5'b0, left_req, right_req, hazard}, 8'b111);
    end

    // Back to idle, then a clean left press with exact latencies.
    applyStimulus(0, 0, 12);
    left = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) checkOutput("press rise early", {7'b0, left_rise}, 8'd0);
      if (i == 5) checkOutput("press rise", {7'b0, left_rise}, 8'd1);
      if (i == 6) checkOutput("press rise width", {6'b0, left_rise, left_req}, 8'b00);
      if (i == 7) checkOutput("press left_req", {7'b0, left_req}, 8'd1);
    end
    applyStimulus(1, 0, 4);

    // Direct swap LEFT -> IDLE -> RIGHT.
    left  = 1'b0;
    right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("swap hazard low", {7'b0, hazard}, 8'd0);
      if (i == 6) checkOutput("swap pre", {6'b0, left_req, right_req}, 8'b10);
      if (i == 7) checkOutput("swap idle gap", {6'b0, left_req, right_req}, 8'b00);
      if (i == 8) checkOutput("swap right", {6'b0, left_req, right_req}, 8'b01);
    end

    // Hazard entry from LEFT and exit back to LEFT.
    applyStimulus(1, 0, 12);
    right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 7) checkOutput("hazard idle gap", {5'b0, left_req, right_req, hazard}, 8'b000);
      if (i == 8) checkOutput("hazard on", {5'b0, left_req, right_req, hazard}, 8'b111);
    end
    right = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 7) checkOutput("hazard exit gap", {5'b0, left_req, right_req, hazard}, 8'b000);
      if (i == 8) checkOutput("hazard exit left", {5'b0, left_req, right_req, hazard}, 8'b100);
    end

    // Bounce: short pulses never flip, the final hold produces one rise.
    applyStimulus(0, 0, 12);
    riseCountL = 0;
    for (int b = 0; b < 4; b++) applyStimulus(((b % 2) == 0), 0, 2);
    applyStimulus(1, 0, 12);
    checkOutput("bounce rise count", 8'(riseCountL), 8'd1);

    // Steady-state vector table.
    foreach (vecs[v]) begin
      applyStimulus(vecs[v].l, vecs[v].r, vecs[v].hold);
      checkOutput($sformatf("vector %0d reqs", v), {5'b0, left_req, right_req, hazard}, {5'b0, vecs[v].expReq});
    end

    // Async reset partway through a debounce count from HAZARD.
    applyStimulus(1, 1, 12);
    left = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("pre-reset hazard", {5'b0, left_req, right_req, hazard}, 8'b111);
    right = 1'b1;
    asyncReset(1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) checkOutput("restart rise early", {7'b0, right_rise}, 8'd0);
      if (i == 5) checkOutput("restart rise", {7'b0, right_rise}, 8'd1);
      if (i == 7) checkOutput("restart right_req", {5'b0, left_req, right_req, hazard}, 8'b010);
    end

    // Randomised segments with occasional asynchronous resets.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) asyncReset($urandom_range(0, 2));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 9));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
